// File: rtl/cv32e40s_data_req_arbiter_pkg.sv
// Types shared by the data request arbiter: OBI data channel payloads and requester IDs.
package cv32e40s_data_req_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

  typedef logic data_req_id_t;

  localparam data_req_id_t DATA_REQ_ID_LSU = 1'b0;
  localparam data_req_id_t DATA_REQ_ID_DBG = 1'b1;

endpackage

// File: rtl/cv32e40s_data_req_arbiter_sva.sv
// Protocol checks for the data request arbiter.
module cv32e40s_data_req_arbiter_sva
  import cv32e40s_data_req_arbiter_pkg::*;
(
  input logic         clk,
  input logic         rst,
  input logic         hold_q,
  input data_req_id_t hold_id_q,
  input logic [1:0]   req_valid_i
);

  // A requester whose request is stalled on the bus must keep it valid until accepted.
  a_held_req_stays_valid: assert property (@(posedge clk) disable iff (rst)
    hold_q |-> req_valid_i[hold_id_q]);

endmodule

// File: rtl/cv32e40s_req_id_fifo.sv
// In-order circular buffer of requester IDs for accepted, not yet answered transfers.
module cv32e40s_req_id_fifo
  import cv32e40s_data_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  data_req_id_t         push_id_i,
  input  logic                 pop_i,
  output data_req_id_t         head_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  data_req_id_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;

  // Next-state for storage, pointers and occupancy; the caller never pushes when full or pops when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_WIDTH{1'b0}} : wr_ptr_q + PTR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_WIDTH{1'b0}} : rd_ptr_q + PTR_WIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= {DEPTH{DATA_REQ_ID_LSU}};
      wr_ptr_q <= {PTR_WIDTH{1'b0}};
      rd_ptr_q <= {PTR_WIDTH{1'b0}};
      count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/cv32e40s_data_req_arbiter.sv
// Round-robin arbiter sharing one OBI data request path between the LSU and a secondary master.
module cv32e40s_data_req_arbiter
  import cv32e40s_data_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid_i,
  input  obi_data_req_t [1:0] req_trans_i,
  input  logic [1:0]          req_lock_i,
  output logic [1:0]          req_ready_o,
  output logic [1:0]          req_resp_valid_o,
  output obi_data_resp_t      req_resp_o,
  output logic                valid_o,
  output obi_data_req_t       trans_o,
  input  logic                ready_i,
  input  logic                resp_valid_i,
  input  obi_data_resp_t      resp_i,
  output logic                busy_o,
  output logic                spurious_resp_o
);

  data_req_id_t         grant_s, head_id_s;
  data_req_id_t         rr_ptr_q, rr_ptr_d, hold_id_q, hold_id_d, lock_id_q, lock_id_d;
  logic                 hold_q, hold_d, lock_q, lock_d;
  logic                 full_s, empty_s, accept_s, pop_s;
  logic [CNT_WIDTH-1:0] count_s;

  // Grant selection: a stalled request, then a locked pair, then round-robin.
  always_comb begin
    grant_s = DATA_REQ_ID_LSU;
    if (hold_q) begin
      grant_s = hold_id_q;
    end else if (lock_q) begin
      grant_s = lock_id_q;
    end else if (&req_valid_i) begin
      grant_s = rr_ptr_q;
    end else if (req_valid_i[DATA_REQ_ID_DBG]) begin
      grant_s = DATA_REQ_ID_DBG;
    end else begin
      grant_s = DATA_REQ_ID_LSU;
    end
  end

  assign valid_o  = req_valid_i[grant_s] && !full_s;
  assign trans_o  = req_trans_i[grant_s];
  assign accept_s = valid_o && ready_i;

  // Only the granted requester sees the downstream ready.
  always_comb begin
    req_ready_o = 2'b00;
    req_ready_o[grant_s] = ready_i && !full_s;
  end

  assign pop_s           = resp_valid_i && !empty_s;
  assign spurious_resp_o = resp_valid_i && empty_s;
  assign req_resp_o      = resp_i;
  assign busy_o          = (count_s != {CNT_WIDTH{1'b0}}) || (|req_valid_i);

  // Route the response to the owner of the oldest outstanding transfer.
  always_comb begin
    req_resp_valid_o = 2'b00;
    req_resp_valid_o[head_id_s] = pop_s;
  end

  // Arbitration state update on accept or stall.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    if (accept_s) begin
      rr_ptr_d  = ~grant_s;
      lock_d    = req_lock_i[grant_s];
      lock_id_d = grant_s;
      hold_d    = 1'b0;
    end else if (valid_o) begin
      hold_d    = 1'b1;
      hold_id_d = grant_s;
    end else begin
      hold_d    = hold_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= DATA_REQ_ID_LSU;
      lock_q    <= 1'b0;
      lock_id_q <= DATA_REQ_ID_LSU;
      hold_q    <= 1'b0;
      hold_id_q <= DATA_REQ_ID_LSU;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
    end
  end

  cv32e40s_req_id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (accept_s),
    .push_id_i (grant_s),
    .pop_i     (pop_s),
    .head_o    (head_id_s),
    .count_o   (count_s),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  cv32e40s_data_req_arbiter_sva u_sva (
    .clk         (clk),
    .rst         (rst),
    .hold_q      (hold_q),
    .hold_id_q   (hold_id_q),
    .req_valid_i (req_valid_i)
  );

endmodule

// File: tb/tb_cv32e40s_data_req_arbiter.sv
// Directed scoreboard bench for the data request arbiter (DEPTH = 2).
`timescale 1ns/1ps
module tb_cv32e40s_data_req_arbiter;
  import cv32e40s_data_req_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid_i, req_lock_i, req_ready_o, req_resp_valid_o;
  obi_data_req_t [1:0] req_trans_i;
  obi_data_resp_t      req_resp_o, resp_i;
  obi_data_req_t       trans_o;
  logic                valid_o, ready_i, resp_valid_i, busy_o, spurious_resp_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] addr; logic [1:0] rdy; } acc_t;
  typedef struct { logic [1:0] rv; logic sp; logic [31:0] rd; } rsp_t;
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];

  always #5 clk = ~clk;

  cv32e40s_data_req_arbiter #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_trans_i      (req_trans_i),
    .req_lock_i       (req_lock_i),
    .req_ready_o      (req_ready_o),
    .req_resp_valid_o (req_resp_valid_o),
    .req_resp_o       (req_resp_o),
    .valid_o          (valid_o),
    .trans_o          (trans_o),
    .ready_i          (ready_i),
    .resp_valid_i     (resp_valid_i),
    .resp_i           (resp_i),
    .busy_o           (busy_o),
    .spurious_resp_o  (spurious_resp_o)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic push_acc(input logic [31:0] addr, input logic [1:0] rdy);
    acc_t e;
    e.addr = addr;
    e.rdy  = rdy;
    exp_acc.push_back(e);
  endtask

  task automatic push_rsp(input logic [1:0] rv, input logic sp, input logic [31:0] rd);
    rsp_t e;
    e.rv = rv;
    e.sp = sp;
    e.rd = rd;
    exp_rsp.push_back(e);
  endtask

  // Drive one cycle of inputs shortly after the rising edge; returns before the falling edge.
  task automatic step(input logic [1:0] v, input logic [1:0] lk, input logic rdy, input logic rv,
                      input logic [31:0] rd, input logic [31:0] a0, input logic [31:0] a1);
    @(posedge clk);
    #1;
    req_valid_i    = v;
    req_lock_i     = lk;
    ready_i        = rdy;
    resp_valid_i   = rv;
    resp_i.rdata   = rd;
    resp_i.err     = 1'b0;
    req_trans_i[0] = '{addr: a0, we: 1'b0, be: 4'hF, wdata: ~a0};
    req_trans_i[1] = '{addr: a1, we: 1'b1, be: 4'h3, wdata: ~a1};
    #1;
  endtask

  // Monitor: compare every accepted transfer and every bus response against the scoreboard.
  always @(negedge clk) begin : monitor
    acc_t ea;
    rsp_t er;
    if (!rst && valid_o && ready_i) begin
      if (exp_acc.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got addr %h expected no accept", trans_o.addr);
      end else begin
        ea = exp_acc.pop_front();
        chk("accept_addr", trans_o.addr, ea.addr);
        chk("accept_ready", 32'(req_ready_o), 32'(ea.rdy));
      end
    end
    if (!rst && resp_valid_i) begin
      if (exp_rsp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got rsp_valid %b expected no response", req_resp_valid_o);
      end else begin
        er = exp_rsp.pop_front();
        chk("resp_route", 32'(req_resp_valid_o), 32'(er.rv));
        chk("resp_spurious", 32'(spurious_resp_o), 32'(er.sp));
        chk("resp_rdata", req_resp_o.rdata, er.rd);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    req_valid_i  = 2'b00;
    req_lock_i   = 2'b00;
    ready_i      = 1'b0;
    resp_valid_i = 1'b0;
    resp_i       = '0;
    req_trans_i  = '0;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(req_resp_valid_o), 32'd0);
    chk("rst_spurious", 32'(spurious_resp_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    #1 rst = 1'b0;

    // Round-robin with both requesters valid, then two in-order responses.
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0010, 32'h2000_0020);
    push_acc(32'h1000_0010, 2'b01);
    chk("rr_busy", 32'(busy_o), 32'd1);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0011, 32'h2000_0020);
    push_acc(32'h2000_0020, 2'b10);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0011, 32'h2000_0021);
    chk("full_valid", 32'(valid_o), 32'd0);
    chk("full_ready", 32'(req_ready_o), 32'd0);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00A0, 32'h0, 32'h0);
    push_rsp(2'b01, 1'b0, 32'h0000_00A0);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00B0, 32'h0, 32'h0);
    push_rsp(2'b10, 1'b0, 32'h0000_00B0);

    // Stall: req0 held for three cycles although rr pointer favours req1.
    step(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0031, 32'h2000_0040);
    push_acc(32'h1000_0031, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step((i == 0) ? 2'b01 : 2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1000_0030, 32'h2000_0040);
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_addr", trans_o.addr, 32'h1000_0030);
      chk("stall_ready", 32'(req_ready_o), 32'd0);
    end
    step(2'b11, 2'b00, 1'b1, 1'b1, 32'h0000_00C0, 32'h1000_0030, 32'h2000_0040);
    push_acc(32'h1000_0030, 2'b01);
    push_rsp(2'b01, 1'b0, 32'h0000_00C0);
    step(2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h2000_0040);
    push_acc(32'h2000_0040, 2'b10);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00C1, 32'h0, 32'h0);
    push_rsp(2'b01, 1'b0, 32'h0000_00C1);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00C2, 32'h0, 32'h0);
    push_rsp(2'b10, 1'b0, 32'h0000_00C2);

    // Locked pair from req1; req0 blocked even while req1 drops valid.
    step(2'b10, 2'b10, 1'b1, 1'b0, 32'h0, 32'h1000_0060, 32'h2000_0050);
    push_acc(32'h2000_0050, 2'b10);
    step(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0060, 32'h2000_0051);
    chk("lock_block_valid", 32'(valid_o), 32'd0);
    chk("lock_block_ready", 32'(req_ready_o), 32'd2);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0060, 32'h2000_0051);
    push_acc(32'h2000_0051, 2'b10);
    step(2'b11, 2'b00, 1'b1, 1'b1, 32'h0000_00D0, 32'h1000_0060, 32'h2000_0052);
    chk("full_pop_valid", 32'(valid_o), 32'd0);
    chk("full_pop_ready", 32'(req_ready_o), 32'd0);
    push_rsp(2'b10, 1'b0, 32'h0000_00D0);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0060, 32'h2000_0052);
    push_acc(32'h1000_0060, 2'b01);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00D1, 32'h0, 32'h0);
    push_rsp(2'b10, 1'b0, 32'h0000_00D1);
    chk("outstanding_busy", 32'(busy_o), 32'd1);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_00D2, 32'h0, 32'h0);
    push_rsp(2'b01, 1'b0, 32'h0000_00D2);
    step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Accept and pop together at count 1: head becomes the newly pushed ID.
    step(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1000_0070, 32'h0);
    push_acc(32'h1000_0070, 2'b01);
    step(2'b10, 2'b00, 1'b1, 1'b1, 32'h0000_00E0, 32'h0, 32'h2000_0080);
    push_acc(32'h2000_0080, 2'b10);
    push_rsp(2'b01, 1'b0, 32'h0000_00E0);
    step(2'b00, 2'b00, 1'b0, 1'b1, 32'h0000_00E1, 32'h0, 32'h0);
    push_rsp(2'b10, 1'b0, 32'h0000_00E1);

    // Spurious response with an empty queue.
    step(2'b00, 2'b00, 1'b0, 1'b1, 32'h0000_00F0, 32'h0, 32'h0);
    push_rsp(2'b00, 1'b1, 32'h0000_00F0);
    chk("spurious_pulse", 32'(spurious_resp_o), 32'd1);
    step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("spurious_clear", 32'(spurious_resp_o), 32'd0);

    // Reset mid-operation clears lock and outstanding count at once.
    step(2'b01, 2'b01, 1'b1, 1'b0, 32'h0, 32'h1000_0090, 32'h2000_00A0);
    push_acc(32'h1000_0090, 2'b01);
    step(2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1000_0090, 32'h2000_00A0);
    chk("pre_rst_lock_valid", 32'(valid_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_lock_valid", 32'(valid_o), 32'd1);
    chk("rst_lock_addr", trans_o.addr, 32'h2000_00A0);
    step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("rst_count_busy", 32'(busy_o), 32'd0);
    #1 rst = 1'b0;
    step(2'b00, 2'b00, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 32'h0);
    push_rsp(2'b00, 1'b1, 32'h0000_0055);
    step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_data_req_arbiter.md
Name: cv32e40s_data_req_arbiter

Overview:
- Two-requester arbiter sharing one OBI data request path: the LSU (requester 0) and a secondary master (requester 1, e.g. debug system bus access).
- Sits in front of the LSU response filter / MPU data path.
- Grants requests round-robin, keeps OBI request stability, and allows a locked back-to-back pair (misaligned split).
- Records the requester ID of every accepted transfer in an in-order queue and routes each bus response back to its owner.

Parameters:
- DEPTH, 2, maximum outstanding accepted transfers (ID queue depth), >=1
- CNT_WIDTH, $clog2(DEPTH+1), outstanding counter width (derived, not overridden)

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- req_valid_i  input  2  per-requester request valid, bit n = requester n
- req_trans_i  input  2 x obi_data_req_t  per-requester transfer attributes
- req_lock_i  input  2  requester n holds grant for its next transfer after this one is accepted
- req_ready_o  output  2  per-requester ready
- req_resp_valid_o  output  2  per-requester response valid
- req_resp_o  output  obi_data_resp_t  response payload, broadcast to both requesters
- valid_o  output  1  downstream request valid
- trans_o  output  obi_data_req_t  downstream transfer (granted requester's trans)
- ready_i  input  1  downstream ready
- resp_valid_i  input  1  downstream response valid
- resp_i  input  obi_data_resp_t  downstream response
- busy_o  output  1  outstanding count nonzero or any req_valid_i set
- spurious_resp_o  output  1  one-cycle pulse when resp_valid_i arrives with empty queue

Behaviour:
- Reset values:
  - count_q=0, ID queue entries=0, rr_ptr_q=0 (requester 0 preferred), hold_q=0, lock_q=0.
  - All outputs except busy_o and trans_o are 0 while no input is asserted.
- Full condition: full = (count_q == DEPTH). While full: valid_o=0, req_ready_o=0. Same-cycle pop does not relieve full (no fall-through).
- Grant selection (combinational, zero latency), in priority order:
  - (a) hold_q set: grant = held ID.
  - (b) lock_q set: grant = locked ID. Other requester is blocked even if the locked requester deasserts valid.
  - (c) both valid: grant = rr_ptr_q.
  - (d) otherwise: the single valid requester.
- Outputs: valid_o = req_valid_i[grant] && !full; trans_o = req_trans_i[grant]; req_ready_o[grant] = ready_i && !full; other ready bit = 0.
- Accept = valid_o && ready_i. On accept:
  - Push grant ID into the queue.
  - rr_ptr_q <= ~grant.
  - lock_q <= req_lock_i[grant]; lock ID = grant.
  - hold_q <= 0.
- Stability: valid_o=1 with ready_i=0 sets hold_q and the held ID. Grant cannot switch until accept. Requester deasserting valid while held violates OBI (assertion).
- Lock release: the next accepted transfer with req_lock_i=0 clears lock_q. Reset clears lock.
- Response routing: on resp_valid_i with count_q>0, req_resp_valid_o[head ID]=1 in the same cycle, then pop. req_resp_o = resp_i always.
- Spurious response: resp_valid_i with count_q==0 gives no req_resp_valid_o, pulses spurious_resp_o, and leaves count unchanged.
- Counter: next = count_q + accept - pop, never wraps (guaranteed by full gating).
- Queue: in-order circular buffer or shift register with DEPTH entries of 1 bit.
- Simultaneous accept and pop with count_q>0: count unchanged; head advances and the new ID is written at the tail.
- Reset mid-operation: all state cleared asynchronously. In-flight bus responses after reset are reported as spurious.

Decomposition:
- cv32e40s_pkg additions:
  - typedef data_req_id_t (1-bit requester ID)
  - localparam DATA_REQ_ID_LSU=0
  - localparam DATA_REQ_ID_DBG=1
- Reuse obi_data_req_t and obi_data_resp_t.
- One natural sub-module: cv32e40s_req_id_fifo (DEPTH x data_req_id_t, push/pop/head/count/full/empty).
- Arbitration and lock logic stay in the top module.

Test Plan:
- Both valid, ready_i=1, rr_ptr=0, DEPTH=2 -> cycle 0 grants req0, cycle 1 grants req1, queue=[0,1]; responses on cycles 3,4 -> req_resp_valid_o=01 then 10.
- req0 valid, ready_i=0 for 3 cycles, req1 asserts in cycle 1 -> grant stays req0, trans_o stable, req1 accepted only after req0's accept.
- req1 sends transfer with lock=1, then req0 and req1 both valid -> req1 granted again regardless of rr_ptr; after req1 accepts with lock=0, req0 granted next.
- Two accepts with no responses (count=2) -> valid_o=0, req_ready_o=00. Same-cycle resp+valid -> no accept that cycle, count=1 after. Next cycle accepts.
- Accept and resp_valid_i in the same cycle at count=1 -> count stays 1, head ID is the newly pushed ID.
- resp_valid_i at count=0 -> spurious_resp_o=1 for one cycle, req_resp_valid_o=00. rst asserted mid-transfer -> count_q=0, lock_q=0 immediately.
